// File: rtl/ram_fifo.sv
// Single-clock FIFO over a simple dual-port register array with wrap-around pointers,
// registered occupancy/status flags, a registered read port and sticky protocol-error flags.
module ram_fifo #(
    parameter int DATA     = 16,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [DATA-1:0]            wr_data,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [DATA-1:0]            rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_THR    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_THR    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [DATA-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr_acc;
    logic            rd_acc;
    logic [CW-1:0]   count_next;

    // Acceptance uses the registered flags only; no same-cycle bypass.
    assign wr_acc     = wr_en && !full;
    assign rd_acc     = rd_en && !empty;
    assign count_next = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_THR == '0);
            almost_empty <= 1'b1;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_acc;

            // Flags follow the next count so they agree with count every cycle.
            count        <= count_next;
            full         <= (count_next == DEPTH_CNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_THR);
            almost_empty <= (count_next <= AE_THR);

            // A new error beats a coincident clear.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo.sv
// Randomised and directed bench for ram_fifo: a queue-based model is compared against every
// output on each falling edge, with literal expectations pinning the directed scenarios.
module tb_ram_fifo;

    localparam int DATA  = 16;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            wr_en;
    logic [DATA-1:0] wr_data;
    logic            rd_en;
    logic            clr_err;
    logic [DATA-1:0] rd_data;
    logic            rd_valid;
    logic            full;
    logic            empty;
    logic            almost_full;
    logic            almost_empty;
    logic [4:0]      count;
    logic            overflow;
    logic            underflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ram_fifo #(.DATA(DATA), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: contents as a queue, outputs derived from its size.
    logic [DATA-1:0] q[$];
    logic [DATA-1:0] m_rd_data = '0;
    bit              m_rd_valid = 1'b0;
    bit              m_over = 1'b0;
    bit              m_under = 1'b0;

    always @(posedge clk) begin
        bit was_full, was_empty;
        if (!reset_n) begin
            q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_over     = 1'b0;
            m_under    = 1'b0;
        end else begin
            was_full   = (q.size() == DEPTH);
            was_empty  = (q.size() == 0);
            m_rd_valid = 1'b0;
            if (rd_en && !was_empty) begin
                m_rd_data  = q.pop_front();
                m_rd_valid = 1'b1;
            end
            if (wr_en && !was_full) q.push_back(wr_data);
            if (wr_en && was_full) m_over = 1'b1;
            else if (clr_err) m_over = 1'b0;
            if (rd_en && was_empty) m_under = 1'b1;
            else if (clr_err) m_under = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model rd_data", 32'(rd_data), 32'(m_rd_data));
            chk("model rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            chk("model count", 32'(count), 32'(q.size()));
            chk("model full", 32'(full), 32'(q.size() == DEPTH));
            chk("model empty", 32'(empty), 32'(q.size() == 0));
            chk("model almost_full", 32'(almost_full), 32'(q.size() >= AF));
            chk("model almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
            chk("model overflow", 32'(overflow), 32'(m_over));
            chk("model underflow", 32'(underflow), 32'(m_under));
        end
    end

    // Drive for one cycle starting at a falling edge; returns at the next falling edge.
    task automatic cyc(input bit w, input logic [DATA-1:0] d, input bit r, input bit c);
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) cyc(1'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("reset count", 32'(count), 0);
        chk("reset empty", 32'(empty), 1);
        chk("reset almost_empty", 32'(almost_empty), 1);
        chk("reset others", {27'd0, full, almost_full, rd_valid, overflow, underflow}, 0);
        chk("reset rd_data", 32'(rd_data), 0);

        // Fill and overflow
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 16'(i), 1'b0, 1'b0);
            chk("fill almost_full", 32'(almost_full), 32'(i + 1 >= 14));
        end
        chk("fill count", 32'(count), 16);
        chk("fill full", 32'(full), 1);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("ovf count", 32'(count), 16);
        chk("ovf flag", 32'(overflow), 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("ovf clear", 32'(overflow), 0);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("drain rd_valid", 32'(rd_valid), 1);
            chk("drain rd_data", 32'(rd_data), 32'(i));
        end
        chk("drain empty", 32'(empty), 1);

        // Underflow with coincident write
        cyc(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("unf flag", 32'(underflow), 1);
        chk("unf rd_valid", 32'(rd_valid), 0);
        chk("unf count", 32'(count), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("unf next read", 32'(rd_data), 32'h1234);
        chk("unf next valid", 32'(rd_valid), 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("unf clear", 32'(underflow), 0);

        // Wrap-around with simultaneous read/write
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(100 + i), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 16'(108 + k), 1'b1, 1'b0);
            chk("wrap count", 32'(count), 8);
            chk("wrap rd_valid", 32'(rd_valid), 1);
            chk("wrap rd_data", 32'(rd_data), 32'(100 + k));
        end
        chk("wrap no errors", {30'd0, overflow, underflow}, 0);

        // Reset mid-operation at count 5
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("mid count before", 32'(count), 5);
        reset_n = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        reset_n = 1'b1;
        chk("mid reset count", 32'(count), 0);
        chk("mid reset empty", 32'(empty), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("mid underflow", 32'(underflow), 1);
        chk("mid rd_valid", 32'(rd_valid), 0);
        chk("mid rd_data", 32'(rd_data), 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 45,
                $urandom_range(0, 99) < 5);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
